axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 i_rd_req  input  1  inst cache read request; held with addr/len stable until i_rd_rdy.
REQ-004 i_rd_addr  input  32  inst burst start address.
REQ-005 i_rd_len  input  4  inst burst beats minus one.
REQ-006 i_rd_rdy  output  1  inst request accepted (AR handshake cycle).
REQ-007 i_ret_valid / i_ret_last / i_ret_data  output  1/1/32  inst return beat, last flag, data.
REQ-008 d_rd_req, d_rd_addr, d_rd_len, d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data: same widths and meaning as the inst ports, for the data cache.
REQ-009 arid  output  4; araddr  output  32; arlen  output  8; arsize  output  3; arburst  output  2; arvalid  output  1: AXI AR channel.
REQ-010 arready  input  1: AXI AR ready.
REQ-011 rid  input  4; rdata  input  32; rlast  input  1; rvalid  input  1: AXI R channel.
REQ-012 rready  output  1: AXI R ready.
REQ-013 i_busy / d_busy  output  1 each: requester has a burst outstanding.

Function
REQ-014 FSM states: IDLE (arvalid=0) and ADDR (arvalid=1); no other states.
REQ-015 Eligibility: requester eligible when req=1, busy=0, and no rdy pulse to it in the previous cycle.
REQ-016 IDLE, any eligible: grant latched; araddr, arlen={4'b0,len}, and arid (inst=0, data=1) registered; next state ADDR.
REQ-017 Default arbitration: data wins when both requesters are eligible.
REQ-018 ADDR: arvalid held and all AR fields held stable until arready=1; in the handshake cycle the granted rdy=1 (combinational: arvalid&&arready&&grant); next state IDLE.
REQ-019 Minimum request-to-handshake latency: 1 cycle (grant cycle, then ADDR); back-to-back AR handshakes spaced at least 2 cycles apart.
REQ-020 arsize constant 3'b010 (4 bytes); arburst constant 2'b01 (INCR).
REQ-021 Busy flag set on the requester's AR handshake.
REQ-022 Busy flag cleared on rvalid&&rready&&rlast with matching rid.
REQ-023 One outstanding burst per requester; at most two in flight in total.
REQ-024 rready constant 1 after reset; caches accept every beat.
REQ-025 Routing: i_ret_valid=rvalid&&rid==0 and d_ret_valid=rvalid&&rid==1; data/last forwarded combinationally, zero latency.
REQ-026 Any other rid: beat consumed and dropped; no busy change.
REQ-027 Busy cleared by rlast and same requester eligible in the same cycle: not granted that cycle (flag registered).
REQ-028 Requester drops req while in ADDR: AR still completes (AXI rule); the rdy pulse is issued and the requester discards it.

Reset
REQ-029 rst=1: state IDLE; arvalid=0; i_busy=d_busy=0; rr pointer=inst; araddr/arlen/arid=0; rdy pulses 0.
REQ-030 Reset mid-burst: busy flags cleared; residual R beats still routed by rid (REQ-025), with no state effect.

Configuration
REQ-031 Macro ARB_RR_EN defined: round-robin arbitration; on a tie, the requester not granted last wins; pointer updates at each AR handshake.
REQ-032 ARB_RR_EN undefined: fixed data-over-inst priority (REQ-017); no pointer register.

Structure
REQ-033 Package axi_arb_pkg holds: ID constants (ID_INST=0, ID_DATA=1); the FSM state encoding; and ARSIZE_W/ARBURST_INCR constants.
REQ-034 One sub-module, arb_grant: combinational eligibility/priority plus the optional RR pointer.

Verification
REQ-035 Inst-only: i_rd_req, addr 0xBFC00000, len 7, arready tied 1 -> arvalid at cycle+1, arid 0, arlen 8'd7, i_rd_rdy one cycle; 8 beats routed to inst with last on the 8th; i_busy 1 until the rlast beat.
REQ-036 Simultaneous requests, ARB_RR_EN off, arready 1 -> data granted first (arid 1), inst second; two-cycle spacing between handshakes.
REQ-037 Same as REQ-036 with ARB_RR_EN on, repeated twice -> grant order data, inst, data, inst.
REQ-038 arready low for 5 cycles in ADDR -> araddr/arlen/arid stable; arvalid high throughout; rdy only on the handshake cycle.
REQ-039 Interleaved R beats of rid 0 and 1, plus one rid 3 beat -> correct per-side routing; rid 3 beat dropped; busy flags clear independently.
REQ-040 rst asserted mid-burst -> next cycle arvalid=0 and busy=0; new request accepted normally afterwards.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// ----------------------------------------------------------------------------
// axi_arb_pkg
// Shared constants and types for the two-requester AXI read arbiter.
//   ID_INST / ID_DATA     : AXI ids used for the inst and data caches
//   ARSIZE_W/ARBURST_INCR : fixed AR burst attributes (4-byte beats, INCR)
//   arb_state_e           : AR channel FSM encoding (IDLE / ADDR)
//   req_id()              : maps a requester select bit (0=inst, 1=data) to id
// ----------------------------------------------------------------------------
package axi_arb_pkg;

    localparam int          NUM_REQ      = 2;
    localparam logic [3:0]  ID_INST      = 4'd0;
    localparam logic [3:0]  ID_DATA      = 4'd1;
    localparam logic [2:0]  ARSIZE_W     = 3'b010;
    localparam logic [1:0]  ARBURST_INCR = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADDR = 1'b1
    } arb_state_e;

    function automatic logic [3:0] req_id(input logic sel);
        return sel ? ID_DATA : ID_INST;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter_if
// AXI read-address (AR) and read-data (R) channel bundle.
//   master : arbiter side (drives AR, rready)
//   slave  : memory side  (drives arready, R channel)
// ----------------------------------------------------------------------------
interface axi_rd_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rlast, rvalid
    );
endinterface

// File: rtl/arb_grant.sv
// ----------------------------------------------------------------------------
// arb_grant
// Combinational eligibility and priority select for the inst (bit 0) and
// data (bit 1) requesters.
//   i_req / i_busy / i_rdy_prev : per-requester request, busy, last-cycle rdy
//   o_any                       : at least one requester eligible
//   o_sel                       : winner, 0 = inst, 1 = data
// Build option ARB_RR_EN: round-robin on ties (adds clk, rst, i_hs, i_hs_sel
// and a one-bit "last granted" pointer). Otherwise data always wins a tie.
// ----------------------------------------------------------------------------
module arb_grant
    import axi_arb_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic               clk,
    input  logic               rst,
    input  logic               i_hs,
    input  logic               i_hs_sel,
`endif
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_busy,
    input  logic [NUM_REQ-1:0] i_rdy_prev,
    output logic               o_any,
    output logic               o_sel
);

    logic [NUM_REQ-1:0] w_elig;

    // A rdy pulse last cycle means the cache may still be dropping its req,
    // so that requester sits out one cycle.
    assign w_elig = i_req & ~i_busy & ~i_rdy_prev;
    assign o_any  = |w_elig;

`ifdef ARB_RR_EN
    // Pointer holds the requester granted at the most recent AR handshake;
    // reset value 0 (inst) makes data win the first tie.
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 1'b0;
        else if (i_hs)
            r_last <= i_hs_sel;
    end

    always_comb begin
        o_sel = w_elig[1];
        if (&w_elig)
            o_sel = ~r_last;
    end
`else
    assign o_sel = w_elig[1];
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter
// Shares one AXI read port between an instruction cache and a data cache.
// One outstanding burst per requester; R beats are routed back by rid.
//   clk, rst                    : clock, synchronous active-high reset
//   i_rd_* / d_rd_*             : cache read requests (req, addr, len, rdy)
//   i_ret_* / d_ret_*           : per-cache return beats (valid, last, data)
//   i_busy / d_busy             : requester has a burst outstanding
//   axi                         : AXI AR/R channels (master modport)
// Build option ARB_RR_EN: round-robin tie-break instead of data priority.
// ----------------------------------------------------------------------------
module axi_rd_arbiter
    import axi_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_rd_req,
    input  logic [31:0]         i_rd_addr,
    input  logic [3:0]          i_rd_len,
    output logic                i_rd_rdy,
    output logic                i_ret_valid,
    output logic                i_ret_last,
    output logic [31:0]         i_ret_data,
    input  logic                d_rd_req,
    input  logic [31:0]         d_rd_addr,
    input  logic [3:0]          d_rd_len,
    output logic                d_rd_rdy,
    output logic                d_ret_valid,
    output logic                d_ret_last,
    output logic [31:0]         d_ret_data,
    output logic                i_busy,
    output logic                d_busy,
    axi_rd_arbiter_if.master    axi
);

    arb_state_e          r_state, w_state_nxt;
    logic                r_grant;
    logic [31:0]         r_araddr;
    logic [7:0]          r_arlen;
    logic [3:0]          r_arid;
    logic [NUM_REQ-1:0]  r_busy;
    logic [NUM_REQ-1:0]  r_rdy_prev;
    logic [NUM_REQ-1:0]  w_rdy;
    logic                w_any, w_sel, w_hs, w_load, w_rlast_hs;

    assign w_hs       = (r_state == ST_ADDR) && axi.arready;
    assign w_rdy      = {w_hs && r_grant, w_hs && !r_grant};
    assign w_rlast_hs = axi.rvalid && axi.rready && axi.rlast;

    arb_grant u_grant (
`ifdef ARB_RR_EN
        .clk        (clk),
        .rst        (rst),
        .i_hs       (w_hs),
        .i_hs_sel   (r_grant),
`endif
        .i_req      ({d_rd_req, i_rd_req}),
        .i_busy     (r_busy),
        .i_rdy_prev (r_rdy_prev),
        .o_any      (w_any),
        .o_sel      (w_sel)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_ADDR;
                    w_load      = 1'b1;
                end
            end
            ST_ADDR: begin
                if (axi.arready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // AR fields are captured at grant and held untouched through ADDR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arid     <= '0;
            r_rdy_prev <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rdy_prev <= w_rdy;
            if (w_load) begin
                r_grant  <= w_sel;
                r_araddr <= w_sel ? d_rd_addr : i_rd_addr;
                r_arlen  <= {4'b0, (w_sel ? d_rd_len : i_rd_len)};
                r_arid   <= req_id(w_sel);
            end
        end
    end

    // Set wins over clear: a requester cannot legally see its own rlast in
    // the cycle its next AR is accepted, so the order only matters for
    // misbehaving slaves. Unknown rids never touch the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_rlast_hs && axi.rid == req_id(1'(k)))
                    r_busy[k] <= 1'b0;
                if (w_rdy[k])
                    r_busy[k] <= 1'b1;
            end
        end
    end

    assign axi.arvalid = (r_state == ST_ADDR);
    assign axi.araddr  = r_araddr;
    assign axi.arlen   = r_arlen;
    assign axi.arid    = r_arid;
    assign axi.arsize  = ARSIZE_W;
    assign axi.arburst = ARBURST_INCR;
    assign axi.rready  = 1'b1;

    assign i_rd_rdy    = w_rdy[0];
    assign d_rd_rdy    = w_rdy[1];
    assign i_busy      = r_busy[0];
    assign d_busy      = r_busy[1];

    // Return path is pure wiring; routing ignores reset and FSM state.
    assign i_ret_valid = axi.rvalid && (axi.rid == ID_INST);
    assign d_ret_valid = axi.rvalid && (axi.rid == ID_DATA);
    assign i_ret_last  = axi.rlast;
    assign d_ret_last  = axi.rlast;
    assign i_ret_data  = axi.rdata;
    assign d_ret_data  = axi.rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
    import axi_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq, dreq;
    logic [31:0] iaddr, daddr;
    logic [3:0]  ilen, dlen;
    logic        irdy, drdy, iret_v, iret_l, dret_v, dret_l, ibusy, dbusy;
    logic [31:0] iret_d, dret_d;

    int n_pass  = 0;
    int n_total = 0;
    int hs_ids[$];
    int hs_cyc[$];

    axi_rd_arbiter_if axi();

    always #5 clk = ~clk;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .i_rd_req(ireq), .i_rd_addr(iaddr), .i_rd_len(ilen), .i_rd_rdy(irdy),
        .i_ret_valid(iret_v), .i_ret_last(iret_l), .i_ret_data(iret_d),
        .d_rd_req(dreq), .d_rd_addr(daddr), .d_rd_len(dlen), .d_rd_rdy(drdy),
        .d_ret_valid(dret_v), .d_ret_last(dret_l), .d_ret_data(dret_d),
        .i_busy(ibusy), .d_busy(dbusy), .axi(axi)
    );

    typedef struct {
        logic        ireq;
        logic        arready;
        logic        rvalid;
        logic        rlast;
        logic [31:0] rdata;
        logic        e_arvalid;
        logic [31:0] e_araddr;
        logic [7:0]  e_arlen;
        logic        e_irdy;
        logic        e_iret_v;
        logic        e_ibusy;
    } vec_t;

    vec_t vt[12];

    // interleaved R beat script (rid, last) with expected routing and busy
    logic [3:0] bid  [7] = '{4'd0, 4'd1, 4'd3, 4'd0, 4'd1, 4'd1, 4'd1};
    logic       bl   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       e_iv [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       e_dv [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       e_ib [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // reference model state for the randomized run
    logic [1:0]  c_req, m_busy, m_rdyp, elig, rdy_e, nbusy;
    logic [31:0] c_addr [2];
    logic [3:0]  c_len  [2];
    logic        m_arv, m_id, m_last, hs, w;
    logic [31:0] m_addr;
    logic [3:0]  m_len;
    int          m_rem  [2];
    int          bk, pick, n_hs;

    function automatic vec_t mk(input logic ir, input logic ar, input logic rv, input logic rl,
                                input logic [31:0] rd, input logic eav, input logic [31:0] ea,
                                input logic [7:0] el, input logic erdy, input logic eiv, input logic eib);
        vec_t v;
        v.ireq = ir; v.arready = ar; v.rvalid = rv; v.rlast = rl; v.rdata = rd;
        v.e_arvalid = eav; v.e_araddr = ea; v.e_arlen = el;
        v.e_irdy = erdy; v.e_iret_v = eiv; v.e_ibusy = eib;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic r_idle();
        axi.rvalid = 1'b0; axi.rid = 4'd0; axi.rlast = 1'b0; axi.rdata = 32'd0;
    endtask

    task automatic beat(input logic [3:0] id, input logic last, input logic [31:0] data);
        axi.rvalid = 1'b1; axi.rid = id; axi.rlast = last; axi.rdata = data;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b1;
        ireq = 1'b0; iaddr = '0; ilen = '0;
        dreq = 1'b0; daddr = '0; dlen = '0;
        axi.arready = 1'b0;
        r_idle();
        nxt();
        rst = 1'b0;
    endtask

    // Raise the selected requests together with single-beat bursts, record
    // handshake order/cycle, then retire the bursts with one rlast beat each.
    task automatic arb_round(input logic wi, input logic wd);
        logic fi, fd;
        hs_ids.delete();
        hs_cyc.delete();
        nxt();
        ireq = wi; iaddr = 32'h0000_1100; ilen = 4'd0;
        dreq = wd; daddr = 32'h0000_2200; dlen = 4'd0;
        axi.arready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            fi = irdy;
            fd = drdy;
            if (fd) begin
                hs_ids.push_back(1); hs_cyc.push_back(c);
                chk("arb_d_arid", axi.arid, 32'(ID_DATA));
                chk("arb_d_araddr", axi.araddr, 32'h0000_2200);
            end
            if (fi) begin
                hs_ids.push_back(0); hs_cyc.push_back(c);
                chk("arb_i_arid", axi.arid, 32'(ID_INST));
                chk("arb_i_araddr", axi.araddr, 32'h0000_1100);
            end
            nxt();
            if (fi) ireq = 1'b0;
            if (fd) dreq = 1'b0;
        end
        chk("arb_hs_count", hs_ids.size(), int'(wi) + int'(wd));
        foreach (hs_ids[j]) begin
            beat(4'(hs_ids[j]), 1'b1, 32'(j));
            nxt();
        end
        r_idle();
        #1;
        chk("arb_busy_clear", {ibusy, dbusy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ireq = 1'b0; iaddr = '0; ilen = '0;
        dreq = 1'b0; daddr = '0; dlen = '0;
        axi.arready = 1'b0;
        r_idle();

        // inst-only burst, arready tied high
        vt[0]  = mk(1, 1, 0, 0, 0, 0, 32'h0,         8'd0, 0, 0, 0);
        vt[1]  = mk(1, 1, 0, 0, 0, 1, 32'hBFC0_0000, 8'd7, 1, 0, 0);
        vt[2]  = mk(0, 1, 0, 0, 0, 0, 32'hBFC0_0000, 8'd7, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            vt[3+k] = mk(0, 1, 1, (k == 7), 32'h1000 + 32'(k), 0, 32'hBFC0_0000, 8'd7, 0, 1, 1);
        vt[11] = mk(0, 1, 0, 0, 0, 0, 32'hBFC0_0000, 8'd7, 0, 0, 0);

        // ---- reset state ----
        do_reset();
        #1;
        chk("rst_arvalid", axi.arvalid, 32'd0);
        chk("rst_ar_fields", {axi.arid, axi.arlen, axi.araddr[19:0]}, 32'd0);
        chk("rst_araddr", axi.araddr, 32'd0);
        chk("rst_busy", {ibusy, dbusy}, 32'd0);
        chk("rst_rdy", {irdy, drdy}, 32'd0);
        chk("rst_rready", axi.rready, 32'd1);
        chk("rst_consts", {axi.arsize, axi.arburst}, {27'd0, 3'b010, 2'b01});

        // ---- table-driven inst-only burst ----
        for (int i = 0; i < 12; i++) begin
            nxt();
            ireq = vt[i].ireq; iaddr = 32'hBFC0_0000; ilen = 4'd7;
            axi.arready = vt[i].arready;
            axi.rvalid = vt[i].rvalid; axi.rid = 4'd0;
            axi.rlast = vt[i].rlast; axi.rdata = vt[i].rdata;
            #1;
            chk($sformatf("vec%0d_arvalid", i), axi.arvalid, 32'(vt[i].e_arvalid));
            chk($sformatf("vec%0d_araddr", i), axi.araddr, vt[i].e_araddr);
            chk($sformatf("vec%0d_arlen", i), axi.arlen, 32'(vt[i].e_arlen));
            chk($sformatf("vec%0d_arid", i), axi.arid, 32'(ID_INST));
            chk($sformatf("vec%0d_irdy", i), irdy, 32'(vt[i].e_irdy));
            chk($sformatf("vec%0d_iret_v", i), iret_v, 32'(vt[i].e_iret_v));
            chk($sformatf("vec%0d_dret_v", i), dret_v, 32'd0);
            chk($sformatf("vec%0d_ibusy", i), ibusy, 32'(vt[i].e_ibusy));
            if (vt[i].e_iret_v) begin
                chk($sformatf("vec%0d_idata", i), iret_d, vt[i].rdata);
                chk($sformatf("vec%0d_ilast", i), iret_l, 32'(vt[i].rlast));
            end
        end

        // ---- simultaneous requests, two rounds: data then inst ----
        for (int r = 0; r < 2; r++) begin
            arb_round(1'b1, 1'b1);
            if (hs_ids.size() == 2) begin
                chk($sformatf("tie%0d_first", r), hs_ids[0], 32'd1);
                chk($sformatf("tie%0d_second", r), hs_ids[1], 32'd0);
                chk($sformatf("tie%0d_gap", r), hs_cyc[1] - hs_cyc[0], 32'd2);
            end
        end
        // data granted alone, then a tie: round-robin hands it to inst
        arb_round(1'b0, 1'b1);
        arb_round(1'b1, 1'b1);
        if (hs_ids.size() == 2) begin
`ifdef ARB_RR_EN
            chk("tie_after_data_first", hs_ids[0], 32'd0);
`else
            chk("tie_after_data_first", hs_ids[0], 32'd1);
`endif
        end

        // ---- arready held low for 5 cycles in ADDR ----
        nxt();
        dreq = 1'b1; daddr = 32'hA000_1000; dlen = 4'd3; axi.arready = 1'b0;
        #1;
        chk("stall_idle_arvalid", axi.arvalid, 32'd0);
        for (int k = 0; k < 5; k++) begin
            nxt();
            #1;
            chk($sformatf("stall%0d_arvalid", k), axi.arvalid, 32'd1);
            chk($sformatf("stall%0d_araddr", k), axi.araddr, 32'hA000_1000);
            chk($sformatf("stall%0d_arlen", k), axi.arlen, 32'd3);
            chk($sformatf("stall%0d_arid", k), axi.arid, 32'd1);
            chk($sformatf("stall%0d_rdy", k), {irdy, drdy}, 32'd0);
        end
        nxt();
        axi.arready = 1'b1;
        #1;
        chk("stall_hs_rdy", {irdy, drdy}, 32'd1);
        nxt();
        dreq = 1'b0;
        #1;
        chk("stall_post_arvalid", axi.arvalid, 32'd0);
        chk("stall_post_rdy", drdy, 32'd0);
        chk("stall_post_dbusy", dbusy, 32'd1);

        // ---- inst burst, then interleaved R beats including rid 3 ----
        ireq = 1'b1; iaddr = 32'h0000_3300; ilen = 4'd0;
        nxt();
        #1;
        chk("ilv_irdy", irdy, 32'd1);
        nxt();
        ireq = 1'b0;
        for (int j = 0; j < 7; j++) begin
            beat(bid[j], bl[j], 32'hC000 + 32'(j));
            #1;
            chk($sformatf("ilv%0d_iv", j), iret_v, 32'(e_iv[j]));
            chk($sformatf("ilv%0d_dv", j), dret_v, 32'(e_dv[j]));
            chk($sformatf("ilv%0d_ibusy", j), ibusy, 32'(e_ib[j]));
            chk($sformatf("ilv%0d_dbusy", j), dbusy, 32'd1);
            if (e_dv[j]) chk($sformatf("ilv%0d_ddata", j), dret_d, 32'hC000 + 32'(j));
            nxt();
        end
        r_idle();
        #1;
        chk("ilv_end_busy", {ibusy, dbusy}, 32'd0);

        // ---- busy cleared by rlast while same requester asks again ----
        ireq = 1'b1; iaddr = 32'h0000_4400; ilen = 4'd0;
        nxt();
        #1;
        chk("r27_first_rdy", irdy, 32'd1);
        nxt();
        ireq = 1'b0;
        nxt();
        ireq = 1'b1; iaddr = 32'h0000_5500;
        beat(4'd0, 1'b1, 32'h55);
        #1;
        chk("r27_last_arvalid", axi.arvalid, 32'd0);
        chk("r27_last_ibusy", ibusy, 32'd1);
        nxt();
        r_idle();
        #1;
        chk("r27_no_grant", axi.arvalid, 32'd0);
        chk("r27_cleared", ibusy, 32'd0);
        nxt();
        #1;
        chk("r27_grant_next", axi.arvalid, 32'd1);
        chk("r27_araddr", axi.araddr, 32'h0000_5500);
        chk("r27_rdy", irdy, 32'd1);
        nxt();
        ireq = 1'b0;
        #1;
        chk("r27_ibusy", ibusy, 32'd1);

        // ---- reset while a data AR is pending and inst is busy ----
        dreq = 1'b1; daddr = 32'h0000_6600; dlen = 4'd0; axi.arready = 1'b0;
        nxt();
        #1;
        chk("r40_pre_arvalid", axi.arvalid, 32'd1);
        nxt();
        rst = 1'b1; dreq = 1'b0;
        beat(4'd0, 1'b1, 32'h77);
        #1;
        chk("r40_route_in_rst", {iret_v, iret_d[7:0]}, {23'd0, 1'b1, 8'h77});
        nxt();
        rst = 1'b0;
        beat(4'd1, 1'b1, 32'h88);
        #1;
        chk("r40_arvalid", axi.arvalid, 32'd0);
        chk("r40_busy", {ibusy, dbusy}, 32'd0);
        chk("r40_residual_dv", dret_v, 32'd1);
        nxt();
        r_idle();
        #1;
        chk("r40_no_effect", {ibusy, dbusy}, 32'd0);
        // new request after reset; requester drops req while in ADDR
        dreq = 1'b1; daddr = 32'h0000_7700; dlen = 4'd0; axi.arready = 1'b0;
        nxt();
        dreq = 1'b0;
        #1;
        chk("r28_arvalid", axi.arvalid, 32'd1);
        chk("r28_araddr", axi.araddr, 32'h0000_7700);
        chk("r28_arid", axi.arid, 32'd1);
        nxt();
        axi.arready = 1'b1;
        #1;
        chk("r28_rdy", drdy, 32'd1);
        nxt();
        #1;
        chk("r28_post", {axi.arvalid, drdy, dbusy}, 32'b001);

        // ---- randomized run against a protocol-level model ----
        do_reset();
        c_req = '0; m_busy = '0; m_rdyp = '0;
        m_arv = 1'b0; m_id = 1'b0; m_last = 1'b0; m_addr = '0; m_len = '0;
        m_rem[0] = 0; m_rem[1] = 0; n_hs = 0;
        c_addr[0] = '0; c_addr[1] = '0; c_len[0] = '0; c_len[1] = '0;
        for (int cy = 0; cy < 3000; cy++) begin
            nxt();
            for (int k = 0; k < 2; k++) begin
                if (!c_req[k] && $urandom_range(3) == 0) begin
                    c_req[k]  = 1'b1;
                    c_addr[k] = $urandom & 32'hFFFF_FFFC;
                    c_len[k]  = 4'($urandom_range(15));
                end
            end
            ireq = c_req[0]; iaddr = c_addr[0]; ilen = c_len[0];
            dreq = c_req[1]; daddr = c_addr[1]; dlen = c_len[1];
            axi.arready = ($urandom_range(2) != 0);
            bk = -1;
            if ($urandom_range(9) == 0) begin
                beat(4'd3, 1'($urandom_range(1)), $urandom);
            end else begin
                pick = $urandom_range(1);
                if (m_rem[pick] == 0) pick = 1 - pick;
                if (m_rem[pick] > 0 && $urandom_range(1) == 1) begin
                    bk = pick;
                    beat(4'(pick), (m_rem[pick] == 1), $urandom);
                end else begin
                    r_idle();
                end
            end
            #1;
            hs    = m_arv && axi.arready;
            rdy_e = {hs && m_id, hs && !m_id};
            chk("rnd_arvalid", axi.arvalid, 32'(m_arv));
            if (m_arv) begin
                chk("rnd_arid", axi.arid, 32'(m_id));
                chk("rnd_araddr", axi.araddr, m_addr);
                chk("rnd_arlen", axi.arlen, 32'(m_len));
            end
            chk("rnd_rdy", {drdy, irdy}, 32'(rdy_e));
            chk("rnd_busy", {dbusy, ibusy}, 32'(m_busy));
            chk("rnd_route", {dret_v, iret_v},
                {30'd0, axi.rvalid && axi.rid == 4'd1, axi.rvalid && axi.rid == 4'd0});
            if (axi.rvalid)
                chk("rnd_data", {iret_d ^ dret_d, 31'd0, iret_l}, {32'd0, 31'd0, axi.rlast});
            // advance model across the coming clock edge
            elig  = c_req & ~m_busy & ~m_rdyp;
            nbusy = m_busy;
            if (bk >= 0) begin
                if (axi.rlast) nbusy[bk] = 1'b0;
                m_rem[bk]--;
            end
            if (hs) begin
                nbusy[m_id]  = 1'b1;
                m_rem[m_id]  = int'(m_len) + 1;
                c_req[m_id]  = 1'b0;
                m_arv        = 1'b0;
                m_last       = m_id;
                n_hs++;
            end else if (!m_arv && elig != 2'b00) begin
`ifdef ARB_RR_EN
                w = (elig == 2'b11) ? !m_last : elig[1];
`else
                w = elig[1];
`endif
                m_arv  = 1'b1;
                m_id   = w;
                m_addr = c_addr[w];
                m_len  = c_len[w];
            end
            m_busy = nbusy;
            m_rdyp = rdy_e;
        end
        chk("rnd_progress", 32'(n_hs > 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
